// File: rtl/picosoc_busdec.sv
// picosoc_busdec: address decoder between the picorv32 native bus master and
// up to eight slave regions. It registers the response, turns decode misses
// (and optional bus timeouts) into an all-ones error response, and keeps an
// error status / faulting-address register pair at ERR_ADDR / ERR_ADDR+4.
//
// Build option: define PICOSOC_BUSDEC_TIMEOUT_EN to include the bus-timeout
// counter and timeout error path. Without it a slave may stall forever.
//
// Handshake: the master holds m_valid (with stable addr/wdata/wstrb) until
// m_ready pulses for one cycle; dropping m_valid earlier aborts the access with
// no m_ready. Toward the slaves, s_valid[sel] stays high until s_ready[sel] is
// seen; s_ready bits of unselected slaves are ignored.
module picosoc_busdec #(
    parameter int                        NUM_SLAVES     = 4,
    parameter logic [32*NUM_SLAVES-1:0]  SLAVE_BASE     = {32'h0200_0000, 32'h0100_0000,
                                                           32'h0001_0000, 32'h0000_0000},
    parameter logic [32*NUM_SLAVES-1:0]  SLAVE_MASK     = {32'hFF00_0000, 32'hFF00_0000,
                                                           32'hFFFF_0000, 32'hFFFF_0000},
    parameter int                        TIMEOUT_CYCLES = 255,
    parameter logic [31:0]               ERR_ADDR       = 32'h03FF_FF00
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       m_valid,
    output logic                       m_ready,
    input  logic [31:0]                m_addr,
    input  logic [31:0]                m_wdata,
    input  logic [3:0]                 m_wstrb,
    output logic [31:0]                m_rdata,
    output logic [NUM_SLAVES-1:0]      s_valid,
    input  logic [NUM_SLAVES-1:0]      s_ready,
    input  logic [32*NUM_SLAVES-1:0]   s_rdata,
    output logic [31:0]                s_addr,
    output logic [31:0]                s_wdata,
    output logic [3:0]                 s_wstrb,
    output logic                       irq_buserr,
    output logic [1:0]                 dbg_state
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [2:0]  sel_q, sel_d;
    logic [31:0] rdata_q, rdata_d;
    logic [31:0] status_q, status_d;
    logic [31:0] fault_q, fault_d;
    logic        irq_q, irq_d;

    logic        hit;
    logic [2:0]  hit_idx;
    logic        sel_ready;
    logic [31:0] sel_rdata;
    logic        is_stat;
    logic        is_fault;
    logic        err_evt;
    logic        err_timeout;

`ifdef PICOSOC_BUSDEC_TIMEOUT_EN
    // Counter value seen in the last ACTIVE cycle a slave is allowed to stall.
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);
    logic [7:0]  cnt_q, cnt_d;
`endif

    assign is_stat  = (m_addr == ERR_ADDR);
    assign is_fault = (m_addr == ERR_ADDR + 32'd4);

    // Address/data go to every slave unregistered; only s_valid is steered.
    assign s_addr     = m_addr;
    assign s_wdata    = m_wdata;
    assign s_wstrb    = m_wstrb;
    assign m_ready    = (state_q == ST_RESP);
    assign m_rdata    = rdata_q;
    assign irq_buserr = irq_q;
    assign dbg_state  = state_q;

    // Address compare; walking downward leaves the lowest hitting index.
    always_comb begin
        hit     = 1'b0;
        hit_idx = 3'd0;
        for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
            if ((m_addr & SLAVE_MASK[32*i +: 32]) == SLAVE_BASE[32*i +: 32]) begin
                hit     = 1'b1;
                hit_idx = 3'(i);
            end
        end
    end

    // Pick out the selected slave's ready/data and drive its one-hot request.
    always_comb begin
        sel_ready = 1'b0;
        sel_rdata = '0;
        s_valid   = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (sel_q == 3'(i)) begin
                sel_ready  = s_ready[i];
                sel_rdata  = s_rdata[32*i +: 32];
                s_valid[i] = (state_q == ST_ACTIVE) && m_valid;
            end
        end
    end

    // Next-state, response data and error-register update.
    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        rdata_d     = rdata_q;
        status_d    = status_q;
        fault_d     = fault_q;
        irq_d       = 1'b0;
        err_evt     = 1'b0;
        err_timeout = 1'b0;
`ifdef PICOSOC_BUSDEC_TIMEOUT_EN
        cnt_d       = cnt_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (m_valid) begin
                    if (is_stat) begin
                        // Read returns the pre-clear value even on a clearing write.
                        rdata_d = status_q;
                        if (m_wstrb != 4'b0000) begin
                            status_d = '0;
                        end
                        state_d = ST_RESP;
                    end else if (is_fault) begin
                        rdata_d = fault_q;
                        state_d = ST_RESP;
                    end else if (hit) begin
                        sel_d   = hit_idx;
`ifdef PICOSOC_BUSDEC_TIMEOUT_EN
                        cnt_d   = '0;
`endif
                        state_d = ST_ACTIVE;
                    end else begin
                        rdata_d = '1;
                        err_evt = 1'b1;
                        state_d = ST_RESP;
                    end
                end
            end
            ST_ACTIVE: begin
                if (!m_valid) begin
                    state_d = ST_IDLE;
                end else if (sel_ready) begin
                    // A ready in the timeout cycle still wins.
                    rdata_d = sel_rdata;
                    state_d = ST_RESP;
`ifdef PICOSOC_BUSDEC_TIMEOUT_EN
                end else if (cnt_q == TO_LAST) begin
                    cnt_d       = cnt_q + 8'd1;
                    rdata_d     = '1;
                    err_evt     = 1'b1;
                    err_timeout = 1'b1;
                    state_d     = ST_RESP;
                end else begin
                    cnt_d = cnt_q + 8'd1;
`endif
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        if (err_evt) begin
            status_d = {1'b1, err_timeout, 26'b0, 1'b1, (err_timeout ? sel_q : 3'b000)};
            fault_d  = m_addr;
            irq_d    = 1'b1;
        end
    end

    // State and datapath registers; reset clears everything at once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            sel_q    <= 3'd0;
            rdata_q  <= '0;
            status_q <= '0;
            fault_q  <= '0;
            irq_q    <= 1'b0;
`ifdef PICOSOC_BUSDEC_TIMEOUT_EN
            cnt_q    <= '0;
`endif
        end else begin
            assert (NUM_SLAVES >= 1 && NUM_SLAVES <= 8 &&
                    TIMEOUT_CYCLES >= 1 && TIMEOUT_CYCLES <= 255);
            state_q  <= state_d;
            sel_q    <= sel_d;
            rdata_q  <= rdata_d;
            status_q <= status_d;
            fault_q  <= fault_d;
            irq_q    <= irq_d;
`ifdef PICOSOC_BUSDEC_TIMEOUT_EN
            cnt_q    <= cnt_d;
`endif
        end
    end

endmodule

// File: tb/tb_picosoc_busdec.sv
// tb_picosoc_busdec: randomized bench for picosoc_busdec. The driver issues one
// master access at a time and plays the slave side; a reference model of the
// decode rules and error registers pushes {irq, rdata} into exp_q, and a
// monitor pops and compares whenever m_ready is seen.
module tb_picosoc_busdec;

    localparam int          NS    = 4;
    localparam int          TO    = 8;
    localparam logic [31:0] ERR_A = 32'h03FF_FF00;
`ifdef PICOSOC_BUSDEC_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    // Slave 1 is widened to 0x0000_0000..0x0001_FFFF so it overlaps slave 0.
    localparam logic [31:0] BASE0 = 32'h0000_0000, MASK0 = 32'hFFFF_0000;
    localparam logic [31:0] BASE1 = 32'h0000_0000, MASK1 = 32'hFFFE_0000;
    localparam logic [31:0] BASE2 = 32'h0100_0000, MASK2 = 32'hFF00_0000;
    localparam logic [31:0] BASE3 = 32'h0200_0000, MASK3 = 32'hFF00_0000;

    logic              clk = 1'b0;
    logic              reset;
    logic              m_valid;
    logic              m_ready;
    logic [31:0]       m_addr;
    logic [31:0]       m_wdata;
    logic [3:0]        m_wstrb;
    logic [31:0]       m_rdata;
    logic [NS-1:0]     s_valid;
    logic [NS-1:0]     s_ready;
    logic [32*NS-1:0]  s_rdata;
    logic [31:0]       s_addr;
    logic [31:0]       s_wdata;
    logic [3:0]        s_wstrb;
    logic              irq_buserr;
    logic [1:0]        dbg_state;

    int total = 0;
    int bad   = 0;

    logic [32:0] exp_q[$];
    logic [31:0] mdl_base [NS];
    logic [31:0] mdl_mask [NS];
    logic [31:0] mdl_status;
    logic [31:0] mdl_fault;

    picosoc_busdec #(
        .NUM_SLAVES     (NS),
        .SLAVE_BASE     ({BASE3, BASE2, BASE1, BASE0}),
        .SLAVE_MASK     ({MASK3, MASK2, MASK1, MASK0}),
        .TIMEOUT_CYCLES (TO),
        .ERR_ADDR       (ERR_A)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_addr     (m_addr),
        .m_wdata    (m_wdata),
        .m_wstrb    (m_wstrb),
        .m_rdata    (m_rdata),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .s_rdata    (s_rdata),
        .s_addr     (s_addr),
        .s_wdata    (s_wdata),
        .s_wstrb    (s_wstrb),
        .irq_buserr (irq_buserr),
        .dbg_state  (dbg_state)
    );

    // Clock.
    always #5 clk = ~clk;

    // Hard stop in case something hangs outside the bounded waits.
    initial begin
        #500000;
        $display("FAIL watchdog: run did not finish, dbg_state=%0d bad=%0d", dbg_state, bad);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Lowest-index slave whose masked address equals its base, or -1.
    function automatic int ref_decode(input logic [31:0] a);
        for (int i = 0; i < NS; i++) begin
            if ((a & mdl_mask[i]) == mdl_base[i]) return i;
        end
        return -1;
    endfunction

    // Monitor: every response is checked against the oldest expectation.
    always @(negedge clk) begin : monitor
        logic [32:0] e;
        if (!reset) begin
            if (m_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_m_ready", 32'(m_ready), 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("m_rdata", m_rdata, e[31:0]);
                    check("irq_on_resp", 32'(irq_buserr), 32'(e[32]));
                end
            end else begin
                check("irq_outside_resp", 32'(irq_buserr), 32'd0);
            end
        end
    end

    // One master access; delay = cycles after s_valid rises before s_ready, -1 = never.
    task automatic run_txn(input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [3:0] wstrb, input int delay, input logic [31:0] sdata);
        int          idx;
        logic [31:0] exp_rd;
        logic        exp_irq;
        int          exp_cyc;
        int          exp_act;
        bit          resp_exp;
        logic [NS-1:0] exp_sv;
        int          cyc;
        int          act_cnt;
        bit          got;
        bit          sv_ok;
        int          budget;

        idx      = -1;
        exp_rd   = '0;
        exp_irq  = 1'b0;
        exp_cyc  = 1;
        exp_act  = 0;
        resp_exp = 1'b1;
        exp_sv   = '0;
        if (addr == ERR_A) begin
            exp_rd = mdl_status;
            if (wstrb != 4'b0) mdl_status = '0;
        end else if (addr == ERR_A + 32'd4) begin
            exp_rd = mdl_fault;
        end else begin
            idx = ref_decode(addr);
            if (idx < 0) begin
                exp_rd     = 32'hFFFF_FFFF;
                exp_irq    = 1'b1;
                mdl_status = {2'b10, 26'b0, 1'b1, 3'b000};
                mdl_fault  = addr;
            end else begin
                exp_sv[idx] = 1'b1;
                if (delay >= 0 && (!TO_EN || delay + 1 <= TO)) begin
                    exp_rd  = sdata;
                    exp_cyc = delay + 2;
                    exp_act = delay + 1;
                end else if (TO_EN) begin
                    exp_rd     = 32'hFFFF_FFFF;
                    exp_irq    = 1'b1;
                    exp_cyc    = TO + 1;
                    exp_act    = TO;
                    mdl_status = {2'b11, 26'b0, 1'b1, 3'(idx)};
                    mdl_fault  = addr;
                end else begin
                    resp_exp = 1'b0;
                end
            end
        end
        if (resp_exp) exp_q.push_back({exp_irq, exp_rd});

        @(posedge clk); #1;
        m_valid = 1'b1;
        m_addr  = addr;
        m_wdata = wdata;
        m_wstrb = wstrb;
        #1;
        check("s_addr", s_addr, addr);
        check("s_wdata", s_wdata, wdata);
        check("s_wstrb", 32'(s_wstrb), 32'(wstrb));

        budget  = resp_exp ? exp_cyc + 20 : 500;
        got     = 1'b0;
        cyc     = 0;
        act_cnt = 0;
        sv_ok   = 1'b1;
        while (!got && cyc < budget) begin
            @(posedge clk); #1;
            cyc++;
            s_rdata = {$urandom, $urandom, $urandom, $urandom};
            s_ready = NS'($urandom_range(0, (1 << NS) - 1));
            if (idx >= 0) s_ready[idx] = 1'b0;
            if (m_ready) begin
                got     = 1'b1;
                m_valid = 1'b0;
            end else begin
                if (s_valid != '0) begin
                    act_cnt++;
                    if (s_valid !== exp_sv) sv_ok = 1'b0;
                end
                if (idx >= 0 && delay >= 0 && cyc == delay + 1) begin
                    s_ready[idx]          = 1'b1;
                    s_rdata[32*idx +: 32] = sdata;
                end
            end
        end

        if (resp_exp) begin
            if (!got) begin
                total++;
                bad++;
                $display("FAIL resp_wait: no m_ready within %0d cycles for addr %h", budget, addr);
                m_valid = 1'b0;
            end
            check("resp_latency", 32'(cyc), 32'(exp_cyc));
            check("svalid_cycles", 32'(act_cnt), 32'(exp_act));
            check("svalid_onehot", 32'(sv_ok), 32'd1);
        end else begin
            check("no_resp_while_stalled", 32'(got), 32'd0);
            m_valid = 1'b0;
            #1;
            check("abort_svalid", 32'(s_valid), 32'd0);
        end
        m_wstrb = 4'b0;
    endtask

    // Main sequence.
    initial begin
        mdl_base   = '{BASE0, BASE1, BASE2, BASE3};
        mdl_mask   = '{MASK0, MASK1, MASK2, MASK3};
        mdl_status = '0;
        mdl_fault  = '0;
        reset   = 1'b1;
        m_valid = 1'b0;
        m_addr  = '0;
        m_wdata = '0;
        m_wstrb = '0;
        s_ready = '0;
        s_rdata = '0;

        repeat (2) @(posedge clk);
        #1;
        check("rst_m_ready", 32'(m_ready), 32'd0);
        check("rst_m_rdata", m_rdata, 32'd0);
        check("rst_s_valid", 32'(s_valid), 32'd0);
        check("rst_irq", 32'(irq_buserr), 32'd0);
        reset = 1'b0;

        // Error registers start cleared.
        run_txn(ERR_A, 32'd0, 4'b0, 0, 32'd0);
        run_txn(ERR_A + 32'd4, 32'd0, 4'b0, 0, 32'd0);

        // Plain read from slave 0 with a two-cycle stall.
        run_txn(32'h0000_0010, 32'd0, 4'b0, 2, 32'h1234_5678);
        // Overlap: slaves 0 and 1 both hit 0x0000_xxxx, lowest index wins.
        run_txn(32'h0000_0004, 32'hCAFE_0001, 4'b1111, 0, 32'hA5A5_0004);
        run_txn(32'h0001_0008, 32'd0, 4'b0, 1, 32'h0001_0008);
        run_txn(32'h0250_0000, 32'd0, 4'b0, 0, 32'h0250_0000);

        // Decode miss and the captured error.
        run_txn(32'h0400_0000, 32'd0, 4'b0, 0, 32'd0);
        run_txn(ERR_A, 32'd0, 4'b0, 0, 32'd0);
        run_txn(ERR_A + 32'd4, 32'd0, 4'b0, 0, 32'd0);

        // Slave 2 never answers: timeout, or an abort when timeouts are not built.
        run_txn(32'h0100_0020, 32'd0, 4'b0, -1, 32'd0);
        run_txn(ERR_A, 32'd0, 4'b0, 0, 32'd0);
        run_txn(ERR_A + 32'd4, 32'd0, 4'b0, 0, 32'd0);

        // Ignored write to the fault register, wstrb=0 access, then clear.
        run_txn(ERR_A + 32'd4, 32'hFFFF_FFFF, 4'b1111, 0, 32'd0);
        run_txn(ERR_A, 32'h1, 4'b0000, 0, 32'd0);
        run_txn(ERR_A, 32'h1, 4'b0001, 0, 32'd0);
        run_txn(ERR_A, 32'd0, 4'b0, 0, 32'd0);

        // Ready arriving in the last allowed cycle wins over the timeout.
        run_txn(32'h0100_0044, 32'd0, 4'b0, TO - 1, 32'h0BAD_F00D);
        run_txn(ERR_A, 32'd0, 4'b0, 0, 32'd0);

        // Reset while a slave holds the bus.
        @(posedge clk); #1;
        m_valid = 1'b1;
        m_addr  = 32'h0100_0040;
        s_ready = '0;
        repeat (3) begin
            @(posedge clk); #1;
        end
        check("mid_active_s_valid", 32'(s_valid), 32'h4);
        reset = 1'b1;
        #1;
        check("async_rst_s_valid", 32'(s_valid), 32'd0);
        check("async_rst_m_ready", 32'(m_ready), 32'd0);
        check("async_rst_irq", 32'(irq_buserr), 32'd0);
        m_valid    = 1'b0;
        mdl_status = '0;
        mdl_fault  = '0;
        @(posedge clk); #1;
        reset = 1'b0;
        run_txn(32'h0000_0100, 32'd0, 4'b0, 1, 32'h5EED_0001);
        run_txn(ERR_A, 32'd0, 4'b0, 0, 32'd0);
        run_txn(ERR_A + 32'd4, 32'd0, 4'b0, 0, 32'd0);

        // Randomized traffic over all regions, misses and error registers.
        for (int n = 0; n < 80; n++) begin
            logic [31:0] a;
            logic [3:0]  ws;
            int          d;
            case ($urandom_range(0, 7))
                0:       a = {16'h0000, 16'($urandom)};
                1:       a = {16'h0001, 16'($urandom)};
                2:       a = {8'h01, 24'($urandom)};
                3:       a = {8'h02, 24'($urandom)};
                4:       a = ERR_A;
                5:       a = ERR_A + 32'd4;
                6:       a = $urandom;
                default: a = {8'h04 + 8'($urandom_range(0, 3)), 24'($urandom)};
            endcase
            ws = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 15)) : 4'b0000;
            d  = $urandom_range(0, 5);
            if (TO_EN && $urandom_range(0, 9) == 0) d = -1;
            run_txn(a, $urandom, ws, d, $urandom);
        end

        repeat (3) @(posedge clk);
        #1;
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
